lenet_mac_accum: RTL and testbench

Streaming accumulator that directly consumes the 32-bit signed product stream of the LeNet 16x16 pipelined multiplier. It sums KERNEL_LEN consecutive products plus a per-output bias, then requantizes the sum to a 16-bit fixed-point activation with optional ReLU and saturation. It sits between the multiplier and the feature-map write-back buffer, one instance per convolution/FC lane.

---
 rtl/lenet_pkg.sv | 21 ++
 rtl/lenet_requant.sv | 35 +++
 rtl/lenet_mac_accum.sv | 123 ++++++++++++
 tb/tb_lenet_mac_accum.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/lenet_pkg.sv
// Shared LeNet datapath constants and the accumulator FSM state type.
package lenet_pkg;

  localparam int PROD_WIDTH_DEF = 32;
  localparam int ACC_WIDTH_DEF  = 40;
  localparam int OUT_WIDTH_DEF  = 16;
  localparam int FRAC_SHIFT_DEF = 8;

  // Products summed per output activation, by layer
  localparam int CONV1_K = 25;
  localparam int CONV2_K = 150;
  localparam int FC1_K   = 400;
  localparam int FC2_K   = 120;
  localparam int FC3_K   = 84;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_e;

endpackage

// File: rtl/lenet_requant.sv
// Combinational requantizer: arithmetic shift, optional ReLU, saturate to OUT_WIDTH.
module lenet_requant #(
  parameter int SUM_WIDTH  = 40,
  parameter int FRAC_SHIFT = 8,
  parameter int OUT_WIDTH  = 16,
  parameter int RELU_EN    = 1
) (
  input  logic [SUM_WIDTH-1:0] sum_i,
  output logic [OUT_WIDTH-1:0] data_o,
  output logic                 sat_o
);

  localparam logic signed [SUM_WIDTH-1:0] Q_MAX =
    {{(SUM_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_WIDTH-1:0] Q_MIN =
    {{(SUM_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [SUM_WIDTH-1:0] q;
  assign q = $signed(sum_i) >>> FRAC_SHIFT;

  always_comb begin
    data_o = q[OUT_WIDTH-1:0];
    sat_o  = 1'b0;
    if ((RELU_EN != 0) && q[SUM_WIDTH-1]) begin
      data_o = '0;
    end else if (q > Q_MAX) begin
      data_o = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      sat_o  = 1'b1;
    end else if (q < Q_MIN) begin
      data_o = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      sat_o  = 1'b1;
    end
  end

endmodule

// File: rtl/lenet_mac_accum.sv
// Streaming product accumulator: KERNEL_LEN products plus bias per output, requantized
// into a single-entry output register with valid/ready backpressure.
module lenet_mac_accum
  import lenet_pkg::*;
#(
  parameter int PROD_WIDTH = PROD_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int KERNEL_LEN = CONV1_K,
  parameter int FRAC_SHIFT = FRAC_SHIFT_DEF,
  parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
  parameter int RELU_EN    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PROD_WIDTH-1:0] in_prod,
  input  logic [OUT_WIDTH-1:0]  bias,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_sat,
  output logic                  busy
);

  localparam int CNT_W = (KERNEL_LEN > 2) ? $clog2(KERNEL_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(KERNEL_LEN - 1);

  acc_state_e           state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_sat_q, out_sat_d;

  logic [ACC_WIDTH-1:0] prod_ext, bias_ext, first_sum, run_sum;
  logic [OUT_WIDTH-1:0] rq_data;
  logic                 rq_sat;
  logic                 accept, last_beat;

  assign prod_ext  = {{(ACC_WIDTH-PROD_WIDTH){in_prod[PROD_WIDTH-1]}}, in_prod};
  // Bias is pre-scaled into the accumulator's fixed-point frame
  assign bias_ext  = {{(ACC_WIDTH-OUT_WIDTH-FRAC_SHIFT){bias[OUT_WIDTH-1]}}, bias,
                      {FRAC_SHIFT{1'b0}}};
  assign first_sum = bias_ext + prod_ext;
  assign run_sum   = acc_q + prod_ext;

  assign in_ready  = !(out_valid_q && !out_ready);
  assign accept    = in_valid && in_ready;
  assign last_beat = (state_q == ACCUM) && (count_q == LAST_CNT);

  lenet_requant #(
    .SUM_WIDTH (ACC_WIDTH),
    .FRAC_SHIFT(FRAC_SHIFT),
    .OUT_WIDTH (OUT_WIDTH),
    .RELU_EN   (RELU_EN)
  ) u_requant (
    .sum_i (run_sum),
    .data_o(rq_data),
    .sat_o (rq_sat)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = first_sum;
          count_d = CNT_W'(1);
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (last_beat) begin
            // A reload in the same cycle as a drain wins over the clear
            out_valid_d = 1'b1;
            out_data_d  = rq_data;
            out_sat_d   = rq_sat;
            count_d     = '0;
            state_d     = IDLE;
          end else begin
            acc_d   = run_sum;
            count_d = count_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign busy      = (count_q != '0);

endmodule

// File: tb/tb_lenet_mac_accum.sv
// Bench for lenet_mac_accum: ReLU and non-ReLU instances share one stimulus stream
// and are checked against an arithmetic model of kernel sums.
module tb_lenet_mac_accum;

  localparam int K = 4;

  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready;
  logic [31:0] in_prod;
  logic [15:0] bias;

  logic        rdy_r, vld_r, sat_r, busy_r;
  logic [15:0] data_r;
  logic        rdy_n, vld_n, sat_n, busy_n;
  logic [15:0] data_n;

  always #5 clk = ~clk;

  lenet_mac_accum #(.KERNEL_LEN(K), .FRAC_SHIFT(8), .RELU_EN(1)) dut_relu (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_r),
    .in_prod(in_prod), .bias(bias), .out_valid(vld_r), .out_ready(out_ready),
    .out_data(data_r), .out_sat(sat_r), .busy(busy_r)
  );

  lenet_mac_accum #(.KERNEL_LEN(K), .FRAC_SHIFT(8), .RELU_EN(0)) dut_lin (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_n),
    .in_prod(in_prod), .bias(bias), .out_valid(vld_n), .out_ready(out_ready),
    .out_data(data_n), .out_sat(sat_n), .busy(busy_n)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference state: beats taken in the current kernel, their running total, output register
  int     m_cnt = 0;
  longint m_acc = 0;
  bit     m_valid = 0;
  int     m_data_r = 0, m_data_n = 0;
  bit     m_sat_r = 0, m_sat_n = 0;

  function automatic void requant(input longint s, input bit relu,
                                  output int d, output bit sat);
    longint q;
    q = s >>> 8;
    d = int'(q);
    sat = 1'b0;
    if (relu && q < 0) d = 0;
    else if (q > 32767) begin d = 32767; sat = 1'b1; end
    else if (q < -32768) begin d = -32768; sat = 1'b1; end
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit v, input logic [31:0] p, input logic [15:0] b,
                      input bit ordy, input bit rst);
    bit accept;
    @(negedge clk);
    reset = rst; in_valid = v; in_prod = p; bias = b; out_ready = ordy;
    #1;
    chk("in_ready_relu", rdy_r, !(m_valid && !ordy));
    chk("in_ready_lin",  rdy_n, !(m_valid && !ordy));
    chk("busy_relu", busy_r, m_cnt != 0);
    chk("busy_lin",  busy_n, m_cnt != 0);
    if (rst) begin
      m_cnt = 0; m_acc = 0; m_valid = 0;
      m_data_r = 0; m_data_n = 0; m_sat_r = 0; m_sat_n = 0;
    end else begin
      accept = v && !(m_valid && !ordy);
      if (m_valid && ordy) m_valid = 0;
      if (accept) begin
        if (m_cnt == 0) m_acc = longint'($signed(b)) * 256;
        m_acc = m_acc + longint'($signed(p));
        m_cnt++;
        if (m_cnt == K) begin
          requant(m_acc, 1'b1, m_data_r, m_sat_r);
          requant(m_acc, 1'b0, m_data_n, m_sat_n);
          m_valid = 1;
          m_cnt = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid_relu", vld_r, m_valid);
    chk("out_valid_lin",  vld_n, m_valid);
    chk("out_data_relu", $signed(data_r), m_data_r);
    chk("out_data_lin",  $signed(data_n), m_data_n);
    chk("out_sat_relu", sat_r, m_sat_r);
    chk("out_sat_lin",  sat_n, m_sat_n);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_prod = '0; bias = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);

    // Reset state
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    chk("reset_ready", rdy_r, 1);
    chk("reset_valid", vld_r, 0);
    chk("reset_data", $signed(data_n), 0);

    // Basic sum: (256+512+768+1024)>>8 = 10, one-cycle pulse
    step(1, 256, 0, 1, 0);
    step(1, 512, 0, 1, 0);
    step(1, 768, 0, 1, 0);
    chk("basic_no_early_valid", vld_r, 0);
    step(1, 1024, 0, 1, 0);
    chk("basic_data", $signed(data_r), 10);
    chk("basic_valid", vld_r, 1);
    step(0, 0, 0, 1, 0);
    chk("basic_pulse_off", vld_r, 0);

    // Negative: ReLU gives 0, linear gives floor(-4000/256) = -16
    repeat (K) step(1, -32'sd1000, 0, 1, 0);
    chk("neg_relu", $signed(data_r), 0);
    chk("neg_lin", $signed(data_n), -16);
    chk("neg_lin_sat", sat_n, 0);

    // Positive saturation
    repeat (K) step(1, 32'h7FFF_FFFF, 0, 1, 0);
    chk("satpos_data", $signed(data_n), 32767);
    chk("satpos_flag", sat_r, 1);

    // Negative saturation
    repeat (K) step(1, 32'h8000_0000, 0, 1, 0);
    chk("satneg_data", $signed(data_n), -32768);
    chk("satneg_flag", sat_n, 1);
    chk("satneg_relu", $signed(data_r), 0);
    step(0, 0, 0, 1, 0);

    // Backpressure: result 400 pending, 5 stalled cycles, then bias -3 + 4x1000 -> 12
    repeat (K) step(1, 25600, 0, 0, 0);
    repeat (5) step(1, 32'd99999, 16'd77, 0, 0);
    chk("bp_ready_low", rdy_r, 0);
    chk("bp_hold", $signed(data_r), 400);
    repeat (K) step(1, 1000, -16'sd3, 1, 0);
    chk("bp_next_kernel", $signed(data_n), 12);

    // Reset mid-kernel discards the partial sum: bias 1 + 4x256 -> 5
    step(1, 5000, 16'd9, 1, 0);
    step(1, 5000, 16'd9, 1, 0);
    step(0, 0, 0, 1, 1);
    repeat (K) step(1, 256, 16'd1, 1, 0);
    chk("rst_mid_data", $signed(data_r), 5);

    // Continuous stream of three kernels
    for (int i = 0; i < 3 * K; i++)
      step(1, $urandom_range(0, 200000) - 100000, 16'($urandom), 1, 0);
    chk("stream_valid", vld_n, 1);

    // Random traffic with backpressure, bubbles and occasional reset
    for (int i = 0; i < 600; i++) begin
      logic [31:0] p;
      p = ($urandom_range(0, 3) == 0) ? 32'($urandom)
                                      : 32'($urandom_range(0, 4000000)) - 32'd2000000;
      step($urandom_range(0, 3) != 0, p, 16'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
